// File: rtl/pop_mode_controller.sv
// POP mode controller: debounced mode button steps modes 0..3 through an all-low guard interval.
// Optional feature: define POP_MODE_LOCK_EN to add the mode_lock input that blocks mode changes.
module pop_mode_controller #(
  parameter int unsigned DEBOUNCE_COUNT = 3,
  parameter int unsigned GUARD_CYCLES   = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mode_button,
  input  logic       debounce_pulse,
  input  logic       slow_pulse,
  input  logic       fast_pulse,
  input  logic       pump_in,
  input  logic       probe_in,
  input  logic       mw_in,
  input  logic       sample_in,
`ifdef POP_MODE_LOCK_EN
  input  logic       mode_lock,
`endif
  output logic       pump,
  output logic       probe,
  output logic       mw,
  output logic       sample,
  output logic       led,
  output logic [1:0] mode,
  output logic       pop_reset
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned GRD_W  = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic {
    RUN   = 1'b0,
    GUARD = 1'b1
  } state_e;

  // Synchronisers and strobe edge register
  logic btn_meta_q, btn_sync_q;
  logic dbp_meta_q, dbp_sync_q, dbp_prev_q;
  logic strobe_c;

  // Debouncer
  logic             accepted_q, accepted_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic             press_ok_c;

  // Mode FSM
  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [MODE_W-1:0]   pending_q, pending_d;
  logic [GRD_W-1:0]    guard_cnt_q, guard_cnt_d;

  // Output registers
  logic pump_q, pump_d;
  logic probe_q, probe_d;
  logic mw_q, mw_d;
  logic sample_q, sample_d;
  logic led_q, led_d;
  logic pop_reset_q, pop_reset_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      dbp_meta_q <= 1'b0;
      dbp_sync_q <= 1'b0;
      dbp_prev_q <= 1'b0;
    end else begin
      btn_meta_q <= mode_button;
      btn_sync_q <= btn_meta_q;
      dbp_meta_q <= debounce_pulse;
      dbp_sync_q <= dbp_meta_q;
      dbp_prev_q <= dbp_sync_q;
    end
  end

  assign strobe_c = dbp_sync_q & ~dbp_prev_q;

`ifdef POP_MODE_LOCK_EN
  logic lock_meta_q, lock_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= mode_lock;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign press_ok_c = press_q & ~lock_sync_q;
`else
  assign press_ok_c = press_q;
`endif

  // Press events need a released level seen since reset, so a button held through reset stays silent
  always_comb begin
    accepted_d  = accepted_q;
    match_cnt_d = match_cnt_q;
    armed_d     = armed_q;
    press_d     = 1'b0;
    if (strobe_c) begin
      if (btn_sync_q) begin
        armed_d = 1'b1;
      end
      if (btn_sync_q == accepted_q) begin
        match_cnt_d = '0;
      end else if (match_cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_COUNT)) begin
        accepted_d  = btn_sync_q;
        match_cnt_d = '0;
        press_d     = ~btn_sync_q & armed_q;
      end else begin
        match_cnt_d = match_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accepted_q  <= 1'b1;
      match_cnt_q <= '0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      accepted_q  <= accepted_d;
      match_cnt_q <= match_cnt_d;
      armed_q     <= armed_d;
      press_q     <= press_d;
    end
  end

  // Mode FSM: presses during GUARD fall through unhandled
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pending_d   = pending_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      RUN: begin
        if (press_ok_c) begin
          pending_d   = mode_q + MODE_W'(1);
          guard_cnt_d = GRD_W'(GUARD_CYCLES - 1);
          state_d     = GUARD;
        end
      end
      GUARD: begin
        if (guard_cnt_q == '0) begin
          state_d = RUN;
          mode_d  = pending_q;
        end else begin
          guard_cnt_d = guard_cnt_q - GRD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      mode_q      <= '0;
      pending_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  // Outputs follow the next state so guard-low starts on the edge that enters GUARD
  always_comb begin
    pump_d      = 1'b0;
    probe_d     = 1'b0;
    mw_d        = 1'b0;
    sample_d    = 1'b0;
    led_d       = 1'b0;
    pop_reset_d = 1'b1;
    if (state_d == RUN) begin
      case (mode_d)
        2'd0: begin
          led_d    = slow_pulse;
          probe_d  = 1'b1;
          sample_d = 1'b1;
        end
        2'd1: begin
          led_d       = 1'b1;
          pump_d      = pump_in;
          probe_d     = probe_in;
          mw_d        = mw_in;
          sample_d    = sample_in;
          pop_reset_d = 1'b0;
        end
        2'd2: begin
          led_d    = fast_pulse;
          sample_d = 1'b1;
        end
        2'd3: begin
          pump_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pump_q      <= 1'b0;
      probe_q     <= 1'b1;
      mw_q        <= 1'b0;
      sample_q    <= 1'b1;
      led_q       <= 1'b0;
      pop_reset_q <= 1'b1;
    end else begin
      pump_q      <= pump_d;
      probe_q     <= probe_d;
      mw_q        <= mw_d;
      sample_q    <= sample_d;
      led_q       <= led_d;
      pop_reset_q <= pop_reset_d;
    end
  end

  assign pump      = pump_q;
  assign probe     = probe_q;
  assign mw        = mw_q;
  assign sample    = sample_q;
  assign led       = led_q;
  assign mode      = mode_q;
  assign pop_reset = pop_reset_q;

endmodule

// File: tb/tb_pop_mode_controller.sv
// Randomised bench for pop_mode_controller against a timestamp-based reference model.
// debounce_pulse runs at an 8-clk period so long button scenarios stay short.
`timescale 1ns/1ps
module tb_pop_mode_controller;

  localparam int unsigned DC = 3;
  localparam int unsigned GC = 25;
  localparam int unsigned DBP_PERIOD = 8;

  logic       clk;
  logic       reset_n;
  logic       mode_button;
  logic       debounce_pulse;
  logic       slow_pulse, fast_pulse;
  logic       pump_in, probe_in, mw_in, sample_in;
  logic       pump, probe, mw, sample, led, pop_reset;
  logic [1:0] mode;
`ifdef POP_MODE_LOCK_EN
  logic       mode_lock;
`endif

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  pop_mode_controller #(.DEBOUNCE_COUNT(DC), .GUARD_CYCLES(GC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mode_button(mode_button),
    .debounce_pulse(debounce_pulse),
    .slow_pulse(slow_pulse),
    .fast_pulse(fast_pulse),
    .pump_in(pump_in),
    .probe_in(probe_in),
    .mw_in(mw_in),
    .sample_in(sample_in),
`ifdef POP_MODE_LOCK_EN
    .mode_lock(mode_lock),
`endif
    .pump(pump),
    .probe(probe),
    .mw(mw),
    .sample(sample),
    .led(led),
    .mode(mode),
    .pop_reset(pop_reset)
  );

  initial clk = 1'b0;
  always #200 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_out();
    return {mode, pump, probe, mw, sample, led, pop_reset};
  endfunction

  // Free-running sources: random flash/POP inputs, square-wave strobe
  initial begin
    int ph = 0;
    slow_pulse = 0; fast_pulse = 0; pump_in = 0; probe_in = 0; mw_in = 0; sample_in = 0;
    debounce_pulse = 0;
    forever begin
      @(negedge clk);
      slow_pulse = 1'($urandom); fast_pulse = 1'($urandom);
      pump_in = 1'($urandom); probe_in = 1'($urandom);
      mw_in = 1'($urandom); sample_in = 1'($urandom);
      ph = (ph + 1) % DBP_PERIOD;
      debounce_pulse = (ph < DBP_PERIOD / 2);
    end
  end

  // Reference model: per-edge sample history, debouncer by run length, guard by end timestamp
  bit   bh[4], dh[4], lh[4];
  bit   m_acc, m_armed, m_press, m_guard;
  int   m_run, m_mode, m_pend, m_cyc, m_guard_end;
  logic [7:0] exp_vec;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin bh[i] = 1; dh[i] = 0; lh[i] = 0; end
    m_acc = 1; m_armed = 0; m_press = 0; m_guard = 0;
    m_run = 0; m_mode = 0; m_pend = 0; m_cyc = 0; m_guard_end = 0;
    exp_vec = 8'h15;
  endtask

  task automatic model_step();
    bit take, b2, s, lk, was_armed;
    bit e_pump, e_probe, e_mw, e_sample, e_led, e_pr;
    m_cyc++;
    for (int i = 3; i > 0; i--) begin bh[i] = bh[i-1]; dh[i] = dh[i-1]; lh[i] = lh[i-1]; end
    bh[0] = mode_button; dh[0] = debounce_pulse;
`ifdef POP_MODE_LOCK_EN
    lh[0] = mode_lock;
`else
    lh[0] = 0;
`endif
    b2 = bh[2]; s = dh[2] && !dh[3]; lk = lh[2];
    take = m_press;
    m_press = 0;
    if (s) begin
      was_armed = m_armed;
      if (b2 == m_acc) m_run = 0;
      else begin
        m_run++;
        if (m_run == DC) begin
          m_acc = b2; m_run = 0;
          m_press = !b2 && was_armed;
        end
      end
      if (b2) m_armed = 1;
    end
    if (m_guard) begin
      if (m_cyc == m_guard_end) begin m_guard = 0; m_mode = m_pend; end
    end else if (take && !lk) begin
      m_pend = (m_mode + 1) % 4; m_guard = 1; m_guard_end = m_cyc + GC;
    end
    {e_pump, e_probe, e_mw, e_sample, e_led, e_pr} = 6'b000001;
    if (!m_guard) begin
      case (m_mode)
        0: begin e_led = slow_pulse; e_probe = 1; e_sample = 1; end
        1: begin e_led = 1; e_pump = pump_in; e_probe = probe_in; e_mw = mw_in;
                 e_sample = sample_in; e_pr = 0; end
        2: begin e_led = fast_pulse; e_sample = 1; end
        default: e_pump = 1;
      endcase
    end
    exp_vec = {2'(m_mode), e_pump, e_probe, e_mw, e_sample, e_led, e_pr};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare plus a log of every mode change
  logic [1:0] mode_log[$];
  logic [1:0] last_mode = 2'd0;
  initial begin
    forever begin
      @(posedge clk);
      #100;
      if (chk_en) begin
        check("cycle", get_out(), exp_vec);
        if (mode !== last_mode) begin
          mode_log.push_back(mode);
          last_mode = mode;
        end
      end
    end
  end

  task automatic press(input int hold, input int rel);
    mode_button = 1'b0;
    repeat (hold) @(negedge clk);
    mode_button = 1'b1;
    repeat (rel) @(negedge clk);
  endtask

  initial begin
    int base;
    int t;
    reset_n = 1'b0;
    mode_button = 1'b1;
`ifdef POP_MODE_LOCK_EN
    mode_lock = 1'b0;
`endif
    repeat (4) @(negedge clk);
    check("reset_vec", get_out(), 8'h15);
    reset_n = 1'b1;
    chk_en = 1;
    repeat (100) @(negedge clk);
    check("idle_mode", mode, 2'd0);
    check("idle_fixed", {probe, sample, pump, mw, pop_reset}, 5'b11001);

    // Four clean presses: 1,2,3,0
    base = mode_log.size();
    press(60, 80);
    check("mode1_pop_reset", pop_reset, 1'b0);
    press(60, 80);
    press(60, 80);
    check("mode3_out", get_out(), 8'hE1);
    press(60, 80);
    check("seq_len", mode_log.size() - base, 4);
    if (mode_log.size() - base == 4) begin
      check("seq0", mode_log[base],   2'd1);
      check("seq1", mode_log[base+1], 2'd2);
      check("seq2", mode_log[base+2], 2'd3);
      check("seq3", mode_log[base+3], 2'd0);
    end

    // Bounce at half the strobe period, then a firm hold
    base = mode_log.size();
    for (int i = 0; i < 20; i++) begin
      mode_button = ~mode_button;
      repeat (DBP_PERIOD / 2) @(negedge clk);
    end
    press(60, 80);
    check("bounce_steps", mode_log.size() - base, 1);
    check("bounce_mode", mode, 2'd1);

    // Reset during GUARD 2->3 with the button still held
    press(60, 80);
    check("mode2", mode, 2'd2);
    mode_button = 1'b0;
    t = 0;
    while (sample !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    check("guard_seen", (t < 100), 1'b1);
    repeat (5) @(negedge clk);
    base = mode_log.size();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    mode_button = 1'b1;
    repeat (150) @(negedge clk);
    check("post_reset_mode", mode, 2'd0);
    check("post_reset_changes", mode_log.size() - base, 1);

    // Random button activity, model-checked every cycle
    for (int i = 0; i < 40; i++) begin
      mode_button = 1'($urandom);
      repeat ($urandom_range(1, 70)) @(negedge clk);
    end
    mode_button = 1'b1;
    repeat (120) @(negedge clk);

`ifdef POP_MODE_LOCK_EN
    begin
      logic [1:0] m0;
      mode_lock = 1'b1;
      repeat (5) @(negedge clk);
      m0 = mode;
      press(60, 80);
      check("locked_mode", mode, m0);
      mode_lock = 1'b0;
      repeat (5) @(negedge clk);
      press(60, 80);
      check("unlocked_mode", mode, 2'(m0 + 2'd1));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
